// File: rtl/bird_flock_fsm.sv
// Round-robin flock controller: steps each bird through clear/move/draw once per frame,
// tracking per-bird flight status, direction hold and fall/escape animation timeout.
module bird_flock_fsm #(
    parameter int unsigned NUM_BIRDS  = 2,
    parameter int unsigned TICK_DIV   = 49_999_999,
    parameter int unsigned LFSR_W     = 8,
    parameter int unsigned DIR_HOLD   = 4,
    parameter int unsigned ANIM_TICKS = 16,
    localparam int unsigned IDX_W     = (NUM_BIRDS > 1) ? $clog2(NUM_BIRDS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_tick,
    input  logic                   draw_done,
    input  logic [NUM_BIRDS-1:0]   shot,
    input  logic                   out_of_ammo,
    input  logic [NUM_BIRDS-1:0]   off_screen,
    output logic [3:0]             state,
    output logic [IDX_W-1:0]       bird_sel,
    output logic [1:0]             move_dir,
    output logic [2*NUM_BIRDS-1:0] bird_status,
    output logic [NUM_BIRDS-1:0]   respawn
);

    localparam int unsigned HOLD_W = $clog2(DIR_HOLD + 1);
    localparam int unsigned ANIM_W = (ANIM_TICKS > 0) ? $clog2(ANIM_TICKS + 1) : 1;
    localparam int unsigned DIV_W  = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;

    localparam logic [1:0] ST_FLYING   = 2'b00;
    localparam logic [1:0] ST_FALLING  = 2'b01;
    localparam logic [1:0] ST_ESCAPING = 2'b10;

    typedef enum logic [3:0] {
        S_HOLD    = 4'h0,
        S_CLEAR   = 4'h1,
        S_MOVE    = 4'h3,
        S_PREHOLD = 4'h4,
        S_DRAW    = 4'h5,
        S_NEXT    = 4'h6,
        S_RESPAWN = 4'hA
    } state_t;

    // Right-shift Galois masks; any mask with the MSB set keeps a nonzero state nonzero.
    function automatic logic [LFSR_W-1:0] taps_for(input int unsigned w);
        logic [LFSR_W-1:0] m;
        case (w)
            4:       m = LFSR_W'(32'h0000_000C);
            5:       m = LFSR_W'(32'h0000_0014);
            6:       m = LFSR_W'(32'h0000_0030);
            7:       m = LFSR_W'(32'h0000_0060);
            8:       m = LFSR_W'(32'h0000_00B8);
            16:      m = LFSR_W'(32'h0000_B400);
            default: begin
                m = '0;
                m[LFSR_W-1] = 1'b1;
                m[LFSR_W-2] = 1'b1;
            end
        endcase
        return m;
    endfunction

    localparam logic [LFSR_W-1:0] LFSR_TAPS = taps_for(LFSR_W);

    state_t             st;
    logic [IDX_W-1:0]   sel;
    logic [1:0]         status_q [NUM_BIRDS];
    logic [1:0]         dir_q    [NUM_BIRDS];
    logic [HOLD_W-1:0]  hold_q   [NUM_BIRDS];
    logic [ANIM_W-1:0]  anim_q   [NUM_BIRDS];
    logic [NUM_BIRDS-1:0] respawn_q;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [DIV_W-1:0]   div_q;

    // Free-running direction source
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_W'(1);
            div_q  <= '0;
        end else if (div_q == '0) begin
            div_q  <= DIV_W'(TICK_DIV);
            lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        end else begin
            div_q  <= div_q - DIV_W'(1);
        end
    end

    // Frame sequencer and per-bird state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st        <= S_PREHOLD;
            sel       <= '0;
            respawn_q <= '0;
            for (int i = 0; i < NUM_BIRDS; i++) begin
                status_q[i] <= ST_FLYING;
                dir_q[i]    <= 2'b00;
                hold_q[i]   <= HOLD_W'(DIR_HOLD);
                anim_q[i]   <= '0;
            end
        end else begin
            respawn_q <= '0;
            case (st)
                S_PREHOLD: if (!frame_tick) st <= S_HOLD;
                S_HOLD: begin
                    if (frame_tick) begin
                        st  <= S_CLEAR;
                        sel <= '0;
                    end
                end
                S_CLEAR: begin
                    if (draw_done)
                        st <= (status_q[sel] == ST_FLYING) ? S_MOVE : S_DRAW;
                end
                S_MOVE: begin
                    if (hold_q[sel] <= HOLD_W'(1)) begin
                        dir_q[sel]  <= lfsr_q[1:0] ^ 2'(sel);
                        hold_q[sel] <= HOLD_W'(DIR_HOLD);
                    end else begin
                        hold_q[sel] <= hold_q[sel] - HOLD_W'(1);
                    end
                    st <= S_DRAW;
                end
                S_DRAW: begin
                    if (draw_done) begin
                        st <= S_NEXT;
                        if (status_q[sel] == ST_FLYING) begin
                            // A hit takes priority over running out of ammo
                            if (shot[sel]) begin
                                status_q[sel] <= ST_FALLING;
                                anim_q[sel]   <= ANIM_W'(ANIM_TICKS);
                            end else if (out_of_ammo) begin
                                status_q[sel] <= ST_ESCAPING;
                                anim_q[sel]   <= ANIM_W'(ANIM_TICKS);
                            end
                        end else if (off_screen[sel] || anim_q[sel] == '0) begin
                            st             <= S_RESPAWN;
                            respawn_q[sel] <= 1'b1;
                        end else begin
                            anim_q[sel] <= anim_q[sel] - ANIM_W'(1);
                        end
                    end
                end
                S_RESPAWN: begin
                    status_q[sel] <= ST_FLYING;
                    dir_q[sel]    <= lfsr_q[1:0];
                    hold_q[sel]   <= HOLD_W'(DIR_HOLD);
                    st            <= S_NEXT;
                end
                S_NEXT: begin
                    if (sel >= IDX_W'(NUM_BIRDS - 1)) begin
                        sel <= '0;
                        st  <= S_PREHOLD;
                    end else begin
                        sel <= sel + IDX_W'(1);
                        st  <= S_CLEAR;
                    end
                end
                default: begin
                    st  <= S_PREHOLD;
                    sel <= '0;
                end
            endcase
        end
    end

    assign state    = st;
    assign bird_sel = sel;
    assign move_dir = dir_q[sel];
    assign respawn  = respawn_q;

    always_comb begin
        bird_status = '0;
        for (int i = 0; i < NUM_BIRDS; i++)
            bird_status[2*i +: 2] = status_q[i];
    end

endmodule
